// File: rtl/start_fifo_srl_ctrl_if.sv
// start_fifo_srl_ctrl_if: producer/consumer handshake bundle for the SRL start FIFO
// Ports (signals):
//   if_write, if_din   producer write request and data
//   if_full_n          1 = a write is accepted this cycle
//   if_read            consumer read request
//   if_dout            registered output token
//   if_empty_n         1 = if_dout holds a valid token
// Modports: master (producer/consumer side), slave (FIFO controller side)
interface start_fifo_srl_ctrl_if #(
    parameter int DATA_WIDTH = 1
);
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    modport master (output if_write, if_din, if_read, input if_full_n, if_dout, if_empty_n);
    modport slave  (input if_write, if_din, if_read, output if_full_n, if_dout, if_empty_n);
endinterface

// File: rtl/start_fifo_srl_ctrl.sv
// start_fifo_srl_ctrl: control for an SRL-based FIFO with a registered output stage
// Ports:
//   ap_clk, ap_rst_n   clock, asynchronous active-low reset
//   bus                producer/consumer handshake (slave modport)
//   srl_we, srl_din    shift enable and data into the external SRL (index 0)
//   srl_addr, srl_dout SRL read address of the oldest entry and its data
//   usedw              total occupancy (SRL entries plus output register)
//   ovf_err, udf_err   sticky write-while-full / read-while-empty flags
module start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 14
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    start_fifo_srl_ctrl_if.slave  bus,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [DATA_WIDTH-1:0] srl_din,
    input  logic [DATA_WIDTH-1:0] srl_dout,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  ovf_err,
    output logic                  udf_err
);
    localparam logic [ADDR_WIDTH:0] ONE  = 1;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
    logic [ADDR_WIDTH:0]   cnt, cnt_next, cnt_m1;
    logic [DATA_WIDTH-1:0] dout_r;
    logic                  out_valid, full_n_r, push, pop, load;
    always_comb begin
        push     = bus.if_write & full_n_r;
        pop      = bus.if_read & out_valid;
        load     = (cnt != '0) & (~out_valid | pop);
        cnt_m1   = cnt - ONE;
        // a simultaneous push and load leaves cnt unchanged: the shift moves the
        // next-oldest token into the slot the address already points at
        cnt_next = (push & ~load) ? cnt + ONE : (load & ~push) ? cnt_m1 : cnt;
    end
    assign srl_we         = push;
    assign srl_din        = bus.if_din;
    assign srl_addr       = (cnt != '0) ? cnt_m1[ADDR_WIDTH-1:0] : '0;
    assign usedw          = cnt + {{ADDR_WIDTH{1'b0}}, out_valid};
    assign bus.if_full_n  = full_n_r;
    assign bus.if_empty_n = out_valid;
    assign bus.if_dout    = dout_r;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            dout_r    <= '0;
            full_n_r  <= 1'b1;
            ovf_err   <= 1'b0;
            udf_err   <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            full_n_r <= cnt_next != FULL;
            // srl_dout is sampled before this edge's shift, so it is the oldest token
            if (load) begin
                dout_r    <= srl_dout;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            ovf_err <= ovf_err | (bus.if_write & ~full_n_r);
            udf_err <= udf_err | (bus.if_read & ~out_valid);
        end
    end
endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// tb_start_fifo_srl_ctrl: self-checking bench with a token-queue reference model
module tb_start_fifo_srl_ctrl;
    localparam int DW = 8, AW = 4, DEPTH = 14;
    typedef struct { logic [DW-1:0] d; int e; } tok_t;

    logic ap_clk = 1'b0, ap_rst_n = 1'b0;
    logic srl_we, ovf_err, udf_err;
    logic [AW-1:0] srl_addr;
    logic [DW-1:0] srl_din, srl_dout;
    logic [AW:0] usedw;
    logic [DW-1:0] srl_mem [0:2**AW-1];

    start_fifo_srl_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    start_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus.slave),
        .srl_we(srl_we), .srl_addr(srl_addr), .srl_din(srl_din), .srl_dout(srl_dout),
        .usedw(usedw), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 ap_clk = ~ap_clk;

    // external shift-register storage: a write shifts everything up, din enters at 0
    always @(posedge ap_clk)
        if (srl_we) begin
            for (int i = 2**AW-1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
            srl_mem[0] <= srl_din;
        end
    assign srl_dout = srl_mem[srl_addr];

    // model: tokens in FIFO order, each tagged with the edge that accepted it;
    // a token becomes visible at the output one edge after it was accepted
    tok_t q[$];
    int edge_n = 0, checks = 0, errors = 0;
    bit m_push, m_pop, m_ovf, m_udf;
    logic [DW-1:0] m_din;

    function automatic bit exp_empty_n();
        return q.size() > 0 && q[0].e < edge_n;
    endfunction
    function automatic bit exp_full_n();
        return q.size() != DEPTH + 1;
    endfunction
    function automatic logic [AW:0] exp_usedw();
        return (AW+1)'(q.size());
    endfunction
    function automatic logic [AW-1:0] exp_addr();
        int c;
        c = q.size() - (exp_empty_n() ? 1 : 0);
        return c > 0 ? AW'(c - 1) : '0;
    endfunction

    task automatic drive(input bit w, input logic [DW-1:0] d, input bit r);
        bus.if_write = w;
        bus.if_din   = d;
        bus.if_read  = r;
        m_din  = d;
        m_push = w && exp_full_n();
        m_pop  = r && exp_empty_n();
        m_ovf  = m_ovf | (w && !exp_full_n());
        m_udf  = m_udf | (r && !exp_empty_n());
        #1;
    endtask

    task automatic tick();
        @(posedge ap_clk);
        edge_n++;
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back('{m_din, edge_n});
        @(negedge ap_clk);
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        bus.if_din   = '0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        q.delete();
        m_push = 0; m_pop = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus.if_full_n !== 1'b1) begin errors++; $display("FAIL reset_full_n got %b want 1", bus.if_full_n); end
        if (bus.if_empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n got %b want 0", bus.if_empty_n); end
        if (usedw !== '0) begin errors++; $display("FAIL reset_usedw got %0d want 0", usedw); end
        if (srl_addr !== '0) begin errors++; $display("FAIL reset_srl_addr got %0d want 0", srl_addr); end
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
        if (udf_err !== 1'b0) begin errors++; $display("FAIL reset_udf got %b want 0", udf_err); end
    endtask

    task automatic test_single_write();
        drive(1, 8'h01, 0);
        checks++;
        if (srl_we !== 1'b1) begin errors++; $display("FAIL single_we0 got %b want 1", srl_we); end
        tick();
        drive(0, 8'h00, 0);
        checks += 2;
        if (srl_we !== 1'b0) begin errors++; $display("FAIL single_we1 got %b want 0", srl_we); end
        if (bus.if_empty_n !== 1'b0) begin errors++; $display("FAIL single_empty1 got %b want 0", bus.if_empty_n); end
        tick();
        checks += 3;
        if (bus.if_empty_n !== 1'b1) begin errors++; $display("FAIL single_empty2 got %b want 1", bus.if_empty_n); end
        if (bus.if_dout !== 8'h01) begin errors++; $display("FAIL single_dout got %h want 01", bus.if_dout); end
        if (usedw !== 5'd1) begin errors++; $display("FAIL single_usedw got %0d want 1", usedw); end
        drive(0, 8'h00, 1);
        tick();
        drive(0, 8'h00, 0);
        checks += 2;
        if (bus.if_empty_n !== 1'b0) begin errors++; $display("FAIL single_drain_empty got %b want 0", bus.if_empty_n); end
        if (usedw !== '0) begin errors++; $display("FAIL single_drain_usedw got %0d want 0", usedw); end
    endtask

    task automatic test_fill_overflow();
        int k = 0;
        logic [DW-1:0] want;
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1, (i % 2) ? 8'hAA : 8'h55, 0);
            tick();
        end
        drive(0, 8'h00, 0);
        checks += 3;
        if (bus.if_full_n !== 1'b0) begin errors++; $display("FAIL fill_full_n got %b want 0", bus.if_full_n); end
        if (usedw !== 5'd15) begin errors++; $display("FAIL fill_usedw got %0d want 15", usedw); end
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL fill_ovf_early got %b want 0", ovf_err); end
        drive(1, 8'hEE, 0);
        checks++;
        if (srl_we !== 1'b0) begin errors++; $display("FAIL ovf_we got %b want 0", srl_we); end
        tick();
        drive(0, 8'h00, 0);
        checks += 2;
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf_err); end
        if (usedw !== 5'd15) begin errors++; $display("FAIL ovf_usedw got %0d want 15", usedw); end
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            checks++;
            if (bus.if_empty_n !== exp_empty_n()) begin errors++; $display("FAIL drain_empty_n got %b want %b", bus.if_empty_n, exp_empty_n()); end
            if (exp_empty_n()) begin
                want = (k % 2) ? 8'hAA : 8'h55;
                checks++;
                if (bus.if_dout !== want) begin errors++; $display("FAIL drain_dout[%0d] got %h want %h", k, bus.if_dout, want); end
                k++;
            end
            drive(0, 8'h00, 1);
            tick();
        end
        drive(0, 8'h00, 1);
        tick();
        drive(0, 8'h00, 0);
        checks += 3;
        if (k !== 15) begin errors++; $display("FAIL drain_count got %0d want 15", k); end
        if (udf_err !== 1'b1) begin errors++; $display("FAIL udf_flag got %b want 1", udf_err); end
        if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_err); end
    endtask

    task automatic test_stream();
        int sent = 0, got = 0, first = -1, last = -1;
        do_reset();
        for (int c = 0; c < 200 && (sent < 100 || q.size() > 0); c++) begin
            checks += 2;
            if (bus.if_empty_n !== exp_empty_n()) begin errors++; $display("FAIL stream_empty_n c%0d got %b want %b", c, bus.if_empty_n, exp_empty_n()); end
            if (usedw > 5'd2) begin errors++; $display("FAIL stream_occupancy c%0d got %0d want <=2", c, usedw); end
            if (exp_empty_n()) begin
                checks++;
                if (bus.if_dout !== q[0].d) begin errors++; $display("FAIL stream_dout c%0d got %h want %h", c, bus.if_dout, q[0].d); end
                if (first < 0) first = c;
                last = c;
                got++;
            end
            drive(sent < 100, DW'($urandom), 1);
            if (sent < 100) sent++;
            tick();
        end
        drive(0, 8'h00, 0);
        checks += 4;
        if (got !== 100) begin errors++; $display("FAIL stream_count got %0d want 100", got); end
        if (first !== 2) begin errors++; $display("FAIL stream_latency got %0d want 2", first); end
        if (last - first !== 99) begin errors++; $display("FAIL stream_rate got %0d want 99", last - first); end
        if (udf_err !== m_udf) begin errors++; $display("FAIL stream_udf got %b want %b", udf_err, m_udf); end
    endtask

    task automatic test_random();
        int ph, wp, rp;
        bit w, r;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            ph = (c / 500) % 4;
            wp = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 60 : 50;
            rp = (ph == 0) ? 30 : (ph == 1) ? 90 : (ph == 2) ? 60 : 50;
            checks += 5;
            if (bus.if_full_n !== exp_full_n()) begin errors++; $display("FAIL rnd_full_n c%0d got %b want %b", c, bus.if_full_n, exp_full_n()); end
            if (bus.if_empty_n !== exp_empty_n()) begin errors++; $display("FAIL rnd_empty_n c%0d got %b want %b", c, bus.if_empty_n, exp_empty_n()); end
            if (usedw !== exp_usedw()) begin errors++; $display("FAIL rnd_usedw c%0d got %0d want %0d", c, usedw, exp_usedw()); end
            if (srl_addr !== exp_addr()) begin errors++; $display("FAIL rnd_srl_addr c%0d got %0d want %0d", c, srl_addr, exp_addr()); end
            if (usedw == 5'd15 && bus.if_full_n) begin errors++; $display("FAIL rnd_full_at_15 c%0d got full_n 1 want 0", c); end
            if (exp_empty_n()) begin
                checks++;
                if (bus.if_dout !== q[0].d) begin errors++; $display("FAIL rnd_dout c%0d got %h want %h", c, bus.if_dout, q[0].d); end
            end
            w = ($urandom_range(0, 99) < wp) && exp_full_n();
            r = ($urandom_range(0, 99) < rp) && exp_empty_n();
            drive(w, DW'($urandom), r);
            checks++;
            if (srl_we !== m_push) begin errors++; $display("FAIL rnd_srl_we c%0d got %b want %b", c, srl_we, m_push); end
            tick();
        end
        drive(0, 8'h00, 0);
        checks += 2;
        if (ovf_err !== 1'b0) begin errors++; $display("FAIL rnd_ovf got %b want 0", ovf_err); end
        if (udf_err !== 1'b0) begin errors++; $display("FAIL rnd_udf got %b want 0", udf_err); end
    endtask

    task automatic test_async_reset();
        int k = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(8'h30 + i), 0);
            tick();
        end
        drive(0, 8'h00, 0);
        checks++;
        if (usedw !== 5'd8) begin errors++; $display("FAIL arst_pre_usedw got %0d want 8", usedw); end
        #2 ap_rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.if_empty_n !== 1'b0) begin errors++; $display("FAIL arst_empty_n got %b want 0", bus.if_empty_n); end
        if (usedw !== '0) begin errors++; $display("FAIL arst_usedw got %0d want 0", usedw); end
        if (bus.if_full_n !== 1'b1) begin errors++; $display("FAIL arst_full_n got %b want 1", bus.if_full_n); end
        q.delete();
        m_push = 0; m_pop = 0; m_ovf = 0; m_udf = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, DW'(8'hC0 + i), 0);
            tick();
        end
        drive(0, 8'h00, 0);
        checks++;
        if (usedw !== 5'd3) begin errors++; $display("FAIL arst_post_usedw got %0d want 3", usedw); end
        for (int c = 0; c < 20 && q.size() > 0; c++) begin
            if (exp_empty_n()) begin
                checks++;
                if (bus.if_dout !== DW'(8'hC0 + k)) begin errors++; $display("FAIL arst_dout[%0d] got %h want %h", k, bus.if_dout, DW'(8'hC0 + k)); end
                k++;
            end
            drive(0, 8'h00, 1);
            tick();
        end
        drive(0, 8'h00, 0);
        checks += 2;
        if (k !== 3) begin errors++; $display("FAIL arst_count got %0d want 3", k); end
        if (bus.if_empty_n !== 1'b0) begin errors++; $display("FAIL arst_final_empty got %b want 0", bus.if_empty_n); end
    endtask

    initial begin
        bus.if_write = 1'b0;
        bus.if_read  = 1'b0;
        bus.if_din   = '0;
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_stream();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/start_fifo_srl_ctrl.md
Name: start_fifo_srl_ctrl

Overview:
Control block for an SRL-based start/stream FIFO. It drives the write-enable and read address of an external shift-register storage array, where a write shifts all entries up and `din` enters at index 0. It adds a registered output stage and exposes HLS-style full_n/empty_n handshakes to the producer and consumer processes. It sits between a producer's start/data output and a consumer process in the dataflow region.

Parameters:
DATA_WIDTH, 1, width of each token
ADDR_WIDTH, 4, width of SRL address; must satisfy 2^ADDR_WIDTH >= DEPTH
DEPTH, 14, number of SRL entries; total capacity is DEPTH+1 (SRL plus output register)

Ports:
ap_clk  in  1  clock; all state updates on rising edge
ap_rst_n  in  1  asynchronous, active-low reset
if_write  in  1  producer write request
if_din  in  DATA_WIDTH  producer data
if_full_n  out  1  registered; 1 = a write is accepted this cycle
if_read  in  1  consumer read request
if_dout  out  DATA_WIDTH  registered output data
if_empty_n  out  1  registered; 1 = if_dout holds a valid token
srl_we  out  1  shift enable to the SRL
srl_addr  out  ADDR_WIDTH  SRL read address (oldest entry)
srl_din  out  DATA_WIDTH  data to the SRL; equals if_din
srl_dout  in  DATA_WIDTH  SRL read data (combinational from srl_addr)
usedw  out  ADDR_WIDTH+1  occupancy, cnt + out_valid
ovf_err  out  1  sticky: write attempted while if_full_n=0
udf_err  out  1  sticky: read attempted while if_empty_n=0

Behaviour:
- State:
  - cnt: 0..DEPTH, SRL occupancy.
  - out_valid: drives if_empty_n.
  - dout_r: drives if_dout.
  - full_n_r: drives if_full_n.
  - ovf_err, udf_err.
- Reset (ap_rst_n=0, async): cnt=0, out_valid=0, dout_r=0, full_n_r=1, ovf_err=0, udf_err=0. Outputs are valid immediately, with no clock needed. Reset mid-operation discards all tokens; SRL contents are not cleared and are irrelevant.
- push = if_write & full_n_r. srl_we = push, combinational. srl_din = if_din.
- pop = if_read & out_valid.
- load = (cnt != 0) & (~out_valid | pop).
- srl_addr = cnt-1 when cnt != 0, else 0; combinational from registered cnt.
- On load: dout_r <= srl_dout (the oldest token, sampled before this edge's shift), out_valid <= 1.
- On pop & ~load: out_valid <= 0; dout_r holds its value.
- cnt_next:
  - cnt + 1 when push & ~load.
  - cnt - 1 when load & ~push.
  - cnt otherwise, including simultaneous push and load. The shift moves the next-oldest token to index cnt-1, so the address stays correct.
- full_n_r <= (cnt_next != DEPTH).
- Latency:
  - Write accepted at edge t on an empty FIFO gives if_empty_n=1 after edge t+1; there is no bypass path.
  - Steady-state throughput is 1 token/cycle with if_read held high.
- No pointer wrap: cnt saturates by construction. A push when full_n_r=0 is ignored and sets ovf_err. A read when out_valid=0 is ignored and sets udf_err. Both flags clear only on reset.
- Ordering is strict FIFO; no token is dropped or duplicated under any read/write pattern.
- usedw = cnt + out_valid, range 0..DEPTH+1.

Test Plan:
- Reset then idle: expect if_full_n=1, if_empty_n=0, usedw=0, srl_addr=0, error flags 0.
- Single write of 1 at cycle 0 with if_read=0: expect srl_we pulse at cycle 0; if_empty_n=1 and if_dout=1 from cycle 2; usedw=1.
- Write 15 alternating tokens (DEPTH=14) with no reads: expect if_full_n=0 after the 15th accept and usedw=15. A 16th write must be ignored and set ovf_err=1.
- Continuous write and read with if_read=1 from cycle 0, 100 tokens in a pseudo-random pattern: expect output order equal to input order, 1 token/cycle after the initial 2-cycle latency, and cnt never exceeding 1.
- Random write/read backpressure for 10k cycles: expect a scoreboard match, usedw equal to the model count, if_full_n never 1 when usedw=15, and no error flags.
- Fill to 8 tokens, then assert ap_rst_n=0 asynchronously mid-cycle: expect if_empty_n=0, usedw=0, if_full_n=1 before the next edge. New writes afterwards return only post-reset data.
